// File: rtl/fifo_mem_sync_if.sv
// rtl/fifo_mem_sync_if.sv - handshake/status bundle for the single-clock FIFO
// FIFO_MEM_SYNC_ERR_EN adds err_clr, overflow and underflow to the bundle.
interface fifo_mem_sync_if #(
   parameter int ADDR_SIZE = 4,
   parameter int DATA_SIZE = 8
);
   logic                 wr_en;
   logic [DATA_SIZE-1:0] wr_data;
   logic                 rd_en;
   logic [DATA_SIZE-1:0] rd_data;
   logic                 rd_valid;
   logic                 full;
   logic                 empty;
   logic                 almost_full;
   logic                 almost_empty;
   logic [ADDR_SIZE:0]   count;
`ifdef FIFO_MEM_SYNC_ERR_EN
   logic                 err_clr;
   logic                 overflow;
   logic                 underflow;
`endif

   modport master (
      output wr_en, wr_data, rd_en,
`ifdef FIFO_MEM_SYNC_ERR_EN
      output err_clr,
      input  overflow, underflow,
`endif
      input  rd_data, rd_valid, full, empty, almost_full, almost_empty, count
   );

   modport slave (
      input  wr_en, wr_data, rd_en,
`ifdef FIFO_MEM_SYNC_ERR_EN
      input  err_clr,
      output overflow, underflow,
`endif
      output rd_data, rd_valid, full, empty, almost_full, almost_empty, count
   );
endinterface

// File: rtl/fifo_mem_sync.sv
// rtl/fifo_mem_sync.sv - single-clock FIFO with storage, pointers, flags, count and registered read
// Optional FIFO_MEM_SYNC_ERR_EN adds sticky overflow/underflow flags cleared by err_clr.
module fifo_mem_sync #(
   parameter int ADDR_SIZE = 4,
   parameter int DATA_SIZE = 8,
   parameter int AFULL_TH  = 12,
   parameter int AEMPTY_TH = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   fifo_mem_sync_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_SIZE;
   localparam int PW    = ADDR_SIZE + 1;
   localparam logic [PW-1:0] AFULL_V  = PW'(AFULL_TH);
   localparam logic [PW-1:0] AEMPTY_V = PW'(AEMPTY_TH);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);

   logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [DATA_SIZE-1:0] rd_data_q, rd_data_d;
   logic                 rd_valid_q, rd_valid_d;
   logic [DATA_SIZE-1:0] mem_q [DEPTH];

   logic [PW-1:0]        count_w;
   logic                 full_w;
   logic                 empty_w;
   logic                 wr_acc;
   logic                 rd_acc;

   // Flags decode purely from registered pointers, so they move only on a clock edge.
   assign count_w = wr_ptr_q - rd_ptr_q;
   assign full_w  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                    (wr_ptr_q[ADDR_SIZE-1:0] == rd_ptr_q[ADDR_SIZE-1:0]);
   assign empty_w = (wr_ptr_q == rd_ptr_q);

   assign wr_acc = bus.wr_en && !full_w;
   assign rd_acc = bus.rd_en && !empty_w;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (rd_acc) begin
         rd_ptr_d   = rd_ptr_q + PTR_ONE;
         rd_data_d  = mem_q[rd_ptr_q[ADDR_SIZE-1:0]];
         rd_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   // Storage is deliberately not reset; stale words are unreachable once the pointers clear.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem_q[wr_ptr_q[ADDR_SIZE-1:0]] <= bus.wr_data;
      end
   end

   assign bus.rd_data      = rd_data_q;
   assign bus.rd_valid     = rd_valid_q;
   assign bus.full         = full_w;
   assign bus.empty        = empty_w;
   assign bus.count        = count_w;
   assign bus.almost_full  = (count_w >= AFULL_V);
   assign bus.almost_empty = (count_w <= AEMPTY_V);

`ifdef FIFO_MEM_SYNC_ERR_EN
   logic overflow_q, overflow_d;
   logic underflow_q, underflow_d;

   // A fresh event in the clearing cycle is applied after the clear so it survives.
   always_comb begin
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (bus.err_clr) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end
      if (bus.wr_en && full_w) begin
         overflow_d = 1'b1;
      end
      if (bus.rd_en && empty_w) begin
         underflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign bus.overflow  = overflow_q;
   assign bus.underflow = underflow_q;
`endif
endmodule
